// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 display path: transmitter states,
// FIFO word layout and command opcodes used by upstream sequencers.
package ili9341_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } tx_state_t;

    localparam int unsigned DC_BIT       = 8;
    localparam int unsigned PAYLOAD_MSB  = 7;
    localparam int unsigned PAYLOAD_LSB  = 0;
    localparam int unsigned PAYLOAD_BITS = PAYLOAD_MSB - PAYLOAD_LSB + 1;

    // One FIFO word: D/C tag above the byte payload
    typedef struct packed {
        logic                    dc;
        logic [PAYLOAD_BITS-1:0] payload;
    } lcd_word_t;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;

    function automatic lcd_word_t make_word(input logic dc,
                                            input logic [PAYLOAD_BITS-1:0] payload);
        lcd_word_t w;
        w.dc      = dc;
        w.payload = payload;
        return w;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Free-running CLK_DIV-cycle interval timer; tick_c marks the last cycle
// of each interval. start restarts the interval, clear parks the timer.
module spi_half_period_timer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             running;

    assign tick_c = running && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ili9341_spi_tx.sv
// Pops 9-bit D/C-tagged words from the display FIFO and shifts the payload
// MSB-first onto the ILI9341 SPI bus (mode 0), keeping CS low across bursts.
module ili9341_spi_tx
    import ili9341_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned WORD_BITS = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_read_enable,
    input  logic [WORD_BITS-1:0] fifo_read_data,
    output logic                 lcd_cs_n,
    output logic                 lcd_sck,
    output logic                 lcd_mosi,
    output logic                 lcd_dc,
    output logic                 busy
);

    localparam int unsigned SHREG_W = PAYLOAD_BITS - 1;

    tx_state_t          state, state_next;
    lcd_word_t          word;
    logic [SHREG_W-1:0] shreg, shreg_next;
    logic [2:0]         bit_cnt, bit_next;
    logic               cs_n_next, sck_next, mosi_next, dc_next;
    logic               timer_start, timer_clear, tick_c;

    assign word = lcd_word_t'(fifo_read_data[DC_BIT:0]);

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (timer_start),
        .clear  (timer_clear),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lcd_cs_n         <= 1'b1;
            lcd_sck          <= 1'b0;
            lcd_mosi         <= 1'b0;
            lcd_dc           <= 1'b0;
            fifo_read_enable <= 1'b0;
            busy             <= 1'b0;
            shreg            <= '0;
            bit_cnt          <= '0;
        end else begin
            state            <= state_next;
            lcd_cs_n         <= cs_n_next;
            lcd_sck          <= sck_next;
            lcd_mosi         <= mosi_next;
            lcd_dc           <= dc_next;
            fifo_read_enable <= (state_next == FETCH);
            busy             <= (state_next != IDLE);
            shreg            <= shreg_next;
            bit_cnt          <= bit_next;
        end
    end

    // Next-state and next-output decode; bus lines move only in LOAD or on SCK falls
    always_comb begin
        state_next  = state;
        cs_n_next   = lcd_cs_n;
        sck_next    = lcd_sck;
        mosi_next   = lcd_mosi;
        dc_next     = lcd_dc;
        shreg_next  = shreg;
        bit_next    = bit_cnt;
        timer_start = 1'b0;
        timer_clear = 1'b0;
        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (!fifo_empty) state_next = FETCH;
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                dc_next     = word.dc;
                mosi_next   = word.payload[PAYLOAD_BITS-1];
                shreg_next  = word.payload[SHREG_W-1:0];
                cs_n_next   = 1'b0;
                sck_next    = 1'b0;
                bit_next    = 3'(PAYLOAD_BITS - 1);
                timer_start = 1'b1;
                state_next  = SHIFT;
            end
            SHIFT: begin
                if (tick_c) begin
                    if (!lcd_sck) begin
                        sck_next = 1'b1;
                    end else begin
                        sck_next = 1'b0;
                        if (bit_cnt == 3'd0) begin
                            if (!fifo_empty) begin
                                state_next  = FETCH;
                                timer_clear = 1'b1;
                            end else begin
                                state_next  = CS_HOLD;
                                timer_start = 1'b1;
                            end
                        end else begin
                            bit_next   = bit_cnt - 3'd1;
                            mosi_next  = shreg[SHREG_W-1];
                            shreg_next = {shreg[SHREG_W-2:0], 1'b0};
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (tick_c) begin
                    cs_n_next   = 1'b1;
                    timer_start = 1'b1;
                    state_next  = CS_GAP;
                end
            end
            CS_GAP: begin
                if (tick_c) begin
                    timer_clear = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// Directed bench for ili9341_spi_tx: a FIFO model feeds words, a bus monitor
// reassembles bytes on SCK rises and checks them against a scoreboard.
module tb_ili9341_spi_tx;

    localparam int unsigned D0 = 2;
    localparam int unsigned D1 = 1;
    localparam logic [5:0] RESET_OUT = 6'b100000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [8:0] fifo_read_data = '0;
    logic       cs0, sck0, mosi0, dc0, rd0, busy0;
    logic       cs1, sck1, mosi1, dc1, rd1, busy1;

    always #5 clk = ~clk;

    ili9341_spi_tx #(.CLK_DIV(D0), .WORD_BITS(9)) dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty | sel),
        .fifo_read_enable(rd0), .fifo_read_data(fifo_read_data),
        .lcd_cs_n(cs0), .lcd_sck(sck0), .lcd_mosi(mosi0), .lcd_dc(dc0), .busy(busy0)
    );

    ili9341_spi_tx #(.CLK_DIV(D1), .WORD_BITS(9)) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty | ~sel),
        .fifo_read_enable(rd1), .fifo_read_data(fifo_read_data),
        .lcd_cs_n(cs1), .lcd_sck(sck1), .lcd_mosi(mosi1), .lcd_dc(dc1), .busy(busy1)
    );

    logic m_cs, m_sck, m_mosi, m_dc, m_rd, m_busy;
    logic [5:0] m_out;
    assign m_cs   = sel ? cs1   : cs0;
    assign m_sck  = sel ? sck1  : sck0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign m_dc   = sel ? dc1   : dc0;
    assign m_rd   = sel ? rd1   : rd0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_out  = {m_cs, m_sck, m_mosi, m_dc, m_rd, m_busy};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int test_id = 0;
    int seen_id = 0;
    int rd_hi, rd_pulses, cs_falls, cs_rises, rises, nonreset;
    int cs_fall_cyc, cs_rise_cyc, last_fall_cyc, busy_fall_cyc, empty_cyc, cs_gap_min;
    int rise_q[$];
    logic [8:0] fq[$];
    logic [8:0] exp_q[$];
    logic [8:0] exp_word;
    logic [7:0] sh = '0;
    int   nbits = 0;
    logic pending = 1'b0;
    logic hold_dc = 1'b0, hold_mosi = 1'b0;
    logic p_cs = 1'b1, p_sck = 1'b0, p_rd = 1'b0, p_busy = 1'b0, p_empty = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO model (data appears after the pop edge) followed by the bus monitor
    always @(negedge clk) begin
        if (pending) begin
            check("fifo_underflow", 32'(fq.size() > 0), 32'(1));
            if (fq.size() > 0) fifo_read_data = fq.pop_front();
            pending = 1'b0;
        end
        if (m_rd) pending = 1'b1;
        fifo_empty = (fq.size() == 0);

        if (test_id != seen_id) begin
            seen_id = test_id;
            rd_hi = 0; rd_pulses = 0; cs_falls = 0; cs_rises = 0; rises = 0; nonreset = 0;
            cs_fall_cyc = 0; cs_rise_cyc = 0; last_fall_cyc = 0; busy_fall_cyc = 0;
            empty_cyc = 0; cs_gap_min = 1000;
            rise_q.delete();
        end
        if (m_out != RESET_OUT) nonreset++;
        if (!rst_n) begin
            nbits = 0;
        end else begin
            if (p_empty && !fifo_empty) empty_cyc = cyc + 1;
            if (m_rd) rd_hi++;
            if (m_rd && !p_rd) rd_pulses++;
            if (!m_cs && p_cs) begin
                cs_falls++;
                if (cs_rises > 0 && (cyc - cs_rise_cyc) < cs_gap_min) cs_gap_min = cyc - cs_rise_cyc;
                cs_fall_cyc = cyc;
            end
            if (m_cs && !p_cs) begin cs_rises++; cs_rise_cyc = cyc; end
            if (!m_sck && p_sck) last_fall_cyc = cyc;
            if (!m_busy && p_busy) busy_fall_cyc = cyc;
            if (m_sck && !p_sck) begin
                rises++;
                rise_q.push_back(cyc);
                check("cs_low_at_rise", 32'(m_cs), 32'(0));
                sh = {sh[6:0], m_mosi};
                hold_dc = m_dc;
                hold_mosi = m_mosi;
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    check("byte_expected", 32'(exp_q.size() > 0), 32'(1));
                    if (exp_q.size() > 0) begin
                        exp_word = exp_q.pop_front();
                        check("byte_dc_payload", 32'({hold_dc, sh}), 32'(exp_word));
                    end
                end
            end else if (m_sck && p_sck) begin
                check("dc_mosi_stable", 32'({m_dc, m_mosi}), 32'({hold_dc, hold_mosi}));
            end
        end
        p_cs = m_cs; p_sck = m_sck; p_rd = m_rd; p_busy = m_busy; p_empty = fifo_empty;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic new_test();
        test_id++;
        step(1);
    endtask

    task automatic push(input logic [8:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (m_busy !== 1'b1 && n < 50) begin step(1); n++; end
        check({tag, "_busy_rise"}, 32'(m_busy), 32'(1));
        n = 0;
        while (m_busy !== 1'b0 && n < 600) begin step(1); n++; end
        check({tag, "_busy_fall"}, 32'(m_busy), 32'(0));
        step(2);
    endtask

    task automatic wait_rises(input int k);
        int n = 0;
        while (rises < k && n < 600) begin step(1); n++; end
        check("rise_wait", 32'(rises >= k), 32'(1));
    endtask

    function automatic int gaps_eq(input int v);
        int c = 0;
        for (int i = 1; i < rise_q.size(); i++)
            if (rise_q[i] - rise_q[i-1] == v) c++;
        return c;
    endfunction

    initial begin
        step(3);
        check("reset_outputs_div2", 32'({cs0, sck0, mosi0, dc0, rd0, busy0}), 32'(RESET_OUT));
        check("reset_outputs_div1", 32'({cs1, sck1, mosi1, dc1, rd1, busy1}), 32'(RESET_OUT));
        rst_n = 1'b1;

        // FIFO empty after reset
        new_test();
        step(100);
        check("idle_read_cycles", 32'(rd_hi), 32'(0));
        check("idle_nonreset_cycles", 32'(nonreset), 32'(0));

        // Single command word
        new_test();
        @(posedge clk); #1;
        push(9'h02A);
        wait_idle("single");
        check("single_read_cycles", 32'(rd_hi), 32'(1));
        check("single_read_pulses", 32'(rd_pulses), 32'(1));
        check("single_cs_fall_latency", 32'(cs_fall_cyc - empty_cyc), 32'(2));
        check("single_first_rise", 32'(rise_q[0] - cs_fall_cyc), 32'(D0));
        check("single_rises", 32'(rises), 32'(8));
        check("single_byte_time", 32'(last_fall_cyc - cs_fall_cyc), 32'(16 * D0));
        check("single_cs_rise", 32'(cs_rise_cyc - last_fall_cyc), 32'(2));
        check("single_busy_fall", 32'(busy_fall_cyc - last_fall_cyc), 32'(4));

        // Preloaded burst
        new_test();
        @(posedge clk); #1;
        push(9'h02C);
        push(9'h1F8);
        push(9'h11F);
        wait_idle("burst");
        check("burst_cs_falls", 32'(cs_falls), 32'(1));
        check("burst_cs_rises", 32'(cs_rises), 32'(1));
        check("burst_rises", 32'(rises), 32'(24));
        check("burst_read_pulses", 32'(rd_pulses), 32'(3));
        check("burst_read_cycles", 32'(rd_hi), 32'(3));
        check("burst_inter_byte_gaps", 32'(gaps_eq(2 * D0 + 2)), 32'(2));
        check("burst_intra_byte_gaps", 32'(gaps_eq(2 * D0)), 32'(21));

        // Word arrives while CS is being held after a burst
        new_test();
        @(posedge clk); #1;
        push(9'h0AB);
        wait_rises(8);
        begin
            int n = 0;
            while (m_sck !== 1'b0 && n < 20) begin step(1); n++; end
        end
        check("hold_sck_low", 32'(m_sck), 32'(0));
        @(posedge clk); #1;
        push(9'h155);
        wait_idle("hold_a");
        wait_idle("hold_b");
        check("hold_rises", 32'(rises), 32'(16));
        check("hold_cs_rises", 32'(cs_rises), 32'(2));
        check("hold_cs_gap_min2", 32'(cs_gap_min >= int'(D0)), 32'(1));

        // Asynchronous reset in the middle of a byte
        new_test();
        @(posedge clk); #1;
        push(9'h1AA);
        wait_rises(4);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'({cs0, sck0, mosi0, dc0, rd0, busy0}), 32'(RESET_OUT));
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        new_test();
        step(50);
        check("post_reset_rises", 32'(rises), 32'(0));
        check("post_reset_reads", 32'(rd_hi), 32'(0));
        check("post_reset_nonreset", 32'(nonreset), 32'(0));

        // CLK_DIV=1 instance
        sel = 1'b1;
        new_test();
        @(posedge clk); #1;
        push(9'h1FF);
        wait_idle("div1_ff");
        check("div1_ff_rises", 32'(rises), 32'(8));
        check("div1_ff_period", 32'(gaps_eq(2)), 32'(7));
        check("div1_ff_byte_time", 32'(last_fall_cyc - cs_fall_cyc), 32'(16));
        new_test();
        @(posedge clk); #1;
        push(9'h000);
        wait_idle("div1_00");
        check("div1_00_rises", 32'(rises), 32'(8));
        check("div1_00_period", 32'(gaps_eq(2)), 32'(7));
        check("div1_00_byte_time", 32'(last_fall_cyc - cs_fall_cyc), 32'(16));

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
